// File: rtl/rr_arb8_pkg.sv
// Shared constants, state encoding and the rotating-priority search for rr_arb8.
package rr_arb8_pkg;

  localparam int NREQ             = 8;
  localparam int IDX_W            = 3;
  localparam int HOLD_MAX_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Returns {found, index} of the first set request at or after ptr, wrapping mod NREQ.
  // The loop walks offsets from farthest to nearest so the nearest hit is the last write.
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = {1'b0, {IDX_W{1'b0}}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arb8_or8way.sv
// Eight-input OR gate used for any-request detection.
module or8way (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  input  logic g,
  input  logic h,
  output logic y
);

  assign y = a | b | c | d | e | f | g | h;

endmodule

// File: rtl/rr_arb8.sv
// 8-requester round-robin arbiter with grant hold, release handshake and timeout.
module rr_arb8
  import rr_arb8_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_id,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic             any_req_s;
  logic [IDX_W:0]   pick_s;
  logic             owner_req_s;
  logic             at_max_s;

  or8way u_or8way (
    .a (req[0]),
    .b (req[1]),
    .c (req[2]),
    .d (req[3]),
    .e (req[4]),
    .f (req[5]),
    .g (req[6]),
    .h (req[7]),
    .y (any_req_s)
  );

  assign pick_s      = rr_pick(req, ptr_q);
  assign owner_req_s = req[gnt_id_q];
  assign at_max_s    = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));

  // Next-state logic: arbitrate in IDLE, hold or release the current owner in GRANT.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          gnt_d      = NREQ'(1) << pick_s[IDX_W-1:0];
          gnt_id_d   = pick_s[IDX_W-1:0];
          hold_cnt_d = {CNT_W{1'b0}};
          state_d    = ST_GRANT;
        end else begin
          gnt_d = {NREQ{1'b0}};
        end
      end
      ST_GRANT: begin
        if (done || !owner_req_s || at_max_s) begin
          gnt_d      = {NREQ{1'b0}};
          state_d    = ST_IDLE;
          ptr_d      = gnt_id_q + IDX_W'(1);
          hold_cnt_d = {CNT_W{1'b0}};
          // Only a pure hold-limit expiry counts as a forced revoke.
          timeout_d  = at_max_s & ~done & owner_req_s;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_d      = {NREQ{1'b0}};
        state_d    = ST_IDLE;
        hold_cnt_d = {CNT_W{1'b0}};
      end
    endcase
    gnt_valid_d = (gnt_d != {NREQ{1'b0}});
  end

  // State and output registers with synchronous reset taking precedence over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= {NREQ{1'b0}};
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= {IDX_W{1'b0}};
      timeout_q   <= 1'b0;
      ptr_q       <= {IDX_W{1'b0}};
      hold_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Scoreboard bench for rr_arb8: a behavioural model predicts each cycle's outputs.
module tb_rr_arb8;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       timeout;

  typedef struct packed {
    logic [7:0] gnt;
    logic       vld;
    logic [2:0] id;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic       m_grant;
  logic [2:0] m_ptr;
  int         m_cnt;
  logic [7:0] m_gnt;
  logic [2:0] m_id;
  logic       m_to;

  rr_arb8 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the reference model by one edge from the given inputs and push the prediction.
  task automatic model_step(input logic [7:0] r, input logic d, input logic rs);
    exp_t e;
    int   pick;
    if (rs) begin
      m_grant = 1'b0; m_ptr = 3'd0; m_cnt = 0;
      m_gnt = 8'h00; m_id = 3'd0; m_to = 1'b0;
    end else if (!m_grant) begin
      m_to = 1'b0;
      pick = -1;
      for (int k = 0; k < 8; k++) begin
        if (pick < 0 && r[(m_ptr + k) % 8]) pick = (m_ptr + k) % 8;
      end
      if (pick >= 0) begin
        m_gnt = 8'h00;
        m_gnt[pick] = 1'b1;
        m_id = 3'(pick);
        m_cnt = 0;
        m_grant = 1'b1;
      end else begin
        m_gnt = 8'h00;
      end
    end else begin
      if (d || !r[m_id] || m_cnt == HOLD - 1) begin
        m_to = !d && r[m_id];
        m_gnt = 8'h00;
        m_grant = 1'b0;
        m_ptr = m_id + 3'd1;
        m_cnt = 0;
      end else begin
        m_to = 1'b0;
        m_cnt++;
      end
    end
    e.gnt = m_gnt;
    e.vld = (m_gnt != 8'h00);
    e.id  = m_id;
    e.to  = m_to;
    exp_q.push_back(e);
  endtask

  // One clock: drive at negedge, predict, sample 1 time unit after posedge and compare.
  task automatic cyc(input logic [7:0] r, input logic d, input logic rs);
    exp_t e;
    @(negedge clk);
    req = r; done = d; rst = rs;
    model_step(r, d, rs);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("gnt",       32'(gnt),       32'(e.gnt));
      check_eq("gnt_valid", 32'(gnt_valid), 32'(e.vld));
      check_eq("gnt_id",    32'(gnt_id),    32'(e.id));
      check_eq("timeout",   32'(timeout),   32'(e.to));
      check_eq("onehot0",   32'($onehot0(gnt)), 32'd1);
    end
  endtask

  initial begin
    req = 8'h00; done = 1'b0; rst = 1'b1;
    m_grant = 1'b0; m_ptr = 3'd0; m_cnt = 0;
    m_gnt = 8'h00; m_id = 3'd0; m_to = 1'b0;

    // Reset with all requests high
    cyc(8'hFF, 1'b0, 1'b1);
    cyc(8'hFF, 1'b0, 1'b1);
    check_eq("reset_gnt", 32'(gnt), 32'h00);
    cyc(8'hFF, 1'b0, 1'b0);
    check_eq("first_gnt", 32'(gnt), 32'h01);
    cyc(8'h00, 1'b1, 1'b0);

    // Single requester 5, done on its third grant cycle
    cyc(8'h20, 1'b0, 1'b0);
    check_eq("single_id", 32'(gnt_id), 32'd5);
    cyc(8'h20, 1'b0, 1'b0);
    cyc(8'h20, 1'b0, 1'b0);
    cyc(8'h20, 1'b1, 1'b0);
    check_eq("single_bubble", 32'(gnt), 32'h00);
    cyc(8'h21, 1'b0, 1'b0);
    check_eq("ptr_wrap", 32'(gnt), 32'h01);
    cyc(8'h21, 1'b1, 1'b0);

    // Round-robin fairness with everyone requesting
    for (int i = 0; i < 18; i++) cyc(8'hFF, 1'b1, 1'b0);

    // Timeout at HOLD cycles
    cyc(8'h00, 1'b1, 1'b0);
    cyc(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < HOLD; i++) cyc(8'h08, 1'b0, 1'b0);
    check_eq("hold_gnt", 32'(gnt), 32'h08);
    cyc(8'h08, 1'b0, 1'b0);
    check_eq("timeout_pulse", 32'(timeout), 32'd1);
    cyc(8'h08, 1'b0, 1'b0);
    check_eq("regrant", 32'(gnt), 32'h08);
    for (int i = 0; i < 8; i++) cyc(8'h08, 1'b0, 1'b0);
    cyc(8'h00, 1'b1, 1'b0);
    cyc(8'h00, 1'b1, 1'b0);

    // Request drop, then reset in the middle of a grant
    cyc(8'h04, 1'b0, 1'b0);
    cyc(8'h04, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    check_eq("drop_no_to", 32'(timeout), 32'd0);
    cyc(8'h44, 1'b0, 1'b0);
    check_eq("after_drop", 32'(gnt), 32'h40);
    cyc(8'h44, 1'b0, 1'b0);
    cyc(8'h44, 1'b0, 1'b1);
    check_eq("mid_rst", 32'(gnt), 32'h00);
    cyc(8'h44, 1'b0, 1'b0);
    check_eq("post_rst", 32'(gnt), 32'h04);
    cyc(8'h44, 1'b1, 1'b0);

    // Exhaustive request sweep, one arbitration each
    for (int r = 0; r < 256; r++) begin
      cyc(8'(r), 1'b1, 1'b0);
      cyc(8'(r), 1'b1, 1'b0);
    end

    // Random traffic including occasional resets
    for (int i = 0; i < 400; i++) begin
      cyc(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
